// File: rtl/blkprefix_array_pkg.sv
// blkprefix_array_pkg: address derivation, decode result type and byte-lane merge shared by the register bank
package blkprefix_array_pkg;
  localparam int MAX_W = 512;
  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_W/8-1:0] sel_t;
  typedef struct packed {
    logic       hit;
    logic       is_scratch;
    logic       unmapped;
    logic [3:0] blk;
    logic [3:0] reg_idx;
  } dec_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int stride_f(input int regs);
    return 1 << clog2(regs);
  endfunction
  function automatic int adr_w_f(input int nblks, input int regs);
    return clog2(stride_f(regs) * (nblks + 1));
  endfunction
  function automatic dec_t decode(input logic [31:0] w, input int nblks, input int regs);
    dec_t d;
    logic [31:0] slot, r;
    slot = w >> clog2(regs);
    r = w & (32'(stride_f(regs)) - 32'd1);
    d.is_scratch = w == 32'd0;
    d.hit = slot >= 32'd1 && slot <= 32'(nblks) && r < 32'(regs);
    d.unmapped = ~(d.hit | d.is_scratch);
    d.blk = d.hit ? 4'(slot - 32'd1) : 4'd0;
    d.reg_idx = d.hit ? 4'(r) : 4'd0;
    return d;
  endfunction
  function automatic word_t byte_merge(input word_t old_v, input word_t new_v, input sel_t sel);
    word_t m;
    for (int i = 0; i < MAX_W / 8; i++) m[i*8 +: 8] = {8{sel[i]}};
    return (new_v & m) | (old_v & ~m);
  endfunction
endpackage

// File: rtl/blkprefix_array_reg.sv
// blkprefix_array_reg: one DATA_W register with byte-lane masked write (wreq/sel/din in; q, write strobe out)
module blkprefix_array_reg
  import blkprefix_array_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wreq,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   q,
  output logic                stb
);
  assign stb = wreq & ~rst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) q <= RST_VAL;
    else if (wreq) q <= DATA_W'(byte_merge(word_t'(q), word_t'(din), sel_t'(sel)));
  end
endmodule

// File: rtl/blkprefix_array.sv
// blkprefix_array: Wishbone register bank (scratch + NUM_BLKS x REGS_PER_BLK regs); ports: wb_* slave bus, scratch_o, regs_o, wr_stb_o
module blkprefix_array
  import blkprefix_array_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                NUM_BLKS     = 2,
  parameter int                REGS_PER_BLK = 3,
  parameter logic [DATA_W-1:0] RST_VAL      = '0,
  localparam int               NREG         = NUM_BLKS * REGS_PER_BLK,
  localparam int               ADR_W        = adr_w_f(NUM_BLKS, REGS_PER_BLK)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [ADR_W+1:2]       wb_adr_i,
  input  logic [DATA_W/8-1:0]    wb_sel_i,
  input  logic [DATA_W-1:0]      wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic                   wb_stall_o,
  output logic [DATA_W-1:0]      wb_dat_o,
  output logic [DATA_W-1:0]      scratch_o,
  output logic [NREG*DATA_W-1:0] regs_o,
  output logic [NREG-1:0]        wr_stb_o
);
  localparam int IDX_W = clog2(NREG + 1);
  logic                en, rd_req, wr_req, rip, wip, ack_q, err_q, d0_req, unused_stb;
  logic [ADR_W-1:0]    d0_adr;
  logic [DATA_W-1:0]   d0_dat;
  logic [DATA_W/8-1:0] d0_sel;
  dec_t                rd_dec, wr_dec;
  logic [IDX_W-1:0]    rd_idx, wr_idx;
  logic [DATA_W-1:0]   q_all [NREG+1];
  logic [NREG:0]       stb_all, wreq;
  function automatic logic [IDX_W-1:0] idx_of(input dec_t d);
    return d.is_scratch || !d.hit ? '0 : IDX_W'(1 + int'(d.blk) * REGS_PER_BLK + int'(d.reg_idx));
  endfunction
  assign en         = wb_cyc_i & wb_stb_i;
  assign rd_req     = en & ~wb_we_i & ~rip;
  assign wr_req     = en & wb_we_i & ~wip;
  assign rd_dec     = decode(32'(wb_adr_i), NUM_BLKS, REGS_PER_BLK);
  assign wr_dec     = decode(32'(d0_adr), NUM_BLKS, REGS_PER_BLK);
  assign rd_idx     = idx_of(rd_dec);
  assign wr_idx     = idx_of(wr_dec);
  assign wb_ack_o   = ack_q & ~rst_i;
  assign wb_err_o   = err_q & ~rst_i;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = en & ~(wb_ack_o | wb_err_o);
  assign scratch_o  = q_all[0];
  assign wr_stb_o   = stb_all[NREG:1];
  assign unused_stb = stb_all[0];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {rip, wip, ack_q, err_q, d0_req} <= '0;
      d0_adr   <= '0;
      d0_dat   <= '0;
      d0_sel   <= '0;
      wb_dat_o <= '0;
    end else begin
      ack_q  <= (rd_req | wr_req) & ~rd_dec.unmapped;
      err_q  <= (rd_req | wr_req) & rd_dec.unmapped;
      rip    <= rd_req | (rip & ~(ack_q | err_q));
      wip    <= wr_req | (wip & ~(ack_q | err_q));
      d0_req <= wr_req;
      d0_adr <= wb_adr_i;
      d0_dat <= wb_dat_i;
      d0_sel <= wb_sel_i;
      if (rd_req) wb_dat_o <= q_all[rd_idx];
    end
  end
  for (genvar i = 0; i <= NREG; i++) begin : g_reg
    assign wreq[i] = d0_req & ~wr_dec.unmapped & (wr_idx == IDX_W'(i));
    blkprefix_array_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wreq  (wreq[i]),
      .sel   (d0_sel),
      .din   (d0_dat),
      .q     (q_all[i]),
      .stb   (stb_all[i])
    );
    if (i > 0) begin : g_out
      assign regs_o[(i-1)*DATA_W +: DATA_W] = q_all[i];
    end
  end
endmodule

// File: tb/tb_blkprefix_array.sv
// tb_blkprefix_array: directed checks of blkprefix_array in default and 5x5 configurations
module tb_blkprefix_array;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [5:0] a = '0;
  logic [3:0] sel = '0;
  logic [31:0] di = '0;
  logic ack, err, rty, stall, ack5, err5, rty5, stall5;
  logic [31:0] dat, scr, dat5, scr5;
  logic [191:0] regs;
  logic [799:0] regs5;
  logic [5:0] wstb;
  logic [24:0] wstb5;
  logic t_stall, t_ack, c_ack, c_err, c5_ack, c5_err;
  logic [31:0] c_dat, c5_dat;
  logic [5:0] c_wstb;
  logic [24:0] c5_wstb;
  logic [191:0] c_regs, exp_regs;
  int passed = 0, total = 0, n;
  int mapped[7] = '{0, 4, 5, 6, 8, 9, 10};
  int unmapped[9] = '{1, 2, 3, 7, 11, 12, 13, 14, 15};
  always #5 clk = ~clk;
  blkprefix_array dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(a[3:0]), .wb_sel_i(sel), .wb_dat_i(di),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall),
    .wb_dat_o(dat), .scratch_o(scr), .regs_o(regs), .wr_stb_o(wstb)
  );
  blkprefix_array #(.NUM_BLKS(5), .REGS_PER_BLK(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(a), .wb_sel_i(sel), .wb_dat_i(di),
    .wb_ack_o(ack5), .wb_err_o(err5), .wb_rty_o(rty5), .wb_stall_o(stall5),
    .wb_dat_o(dat5), .scratch_o(scr5), .regs_o(regs5), .wr_stb_o(wstb5)
  );
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask
  task automatic xfer(input logic w, input logic [5:0] adr, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; a = adr; di = d; sel = s;
    @(negedge clk);
    t_stall = stall; t_ack = ack | err;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    c_ack = ack; c_err = err; c_dat = dat; c_wstb = wstb; c_regs = regs;
    c5_ack = ack5; c5_err = err5; c5_dat = dat5; c5_wstb = wstb5;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    exp_regs = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rty", rty, 0);
    chk("rst_dat", dat, 0);
    chk("rst_scratch", scr, 0);
    chk("rst_regs", regs, 0);
    chk("rst_wstb", wstb, 0);
    foreach (mapped[k]) begin
      xfer(1'b0, 6'(mapped[k]), 32'h0, 4'h0);
      chk($sformatf("rd_ack_w%0d", mapped[k]), c_ack, 1);
      chk($sformatf("rd_err_w%0d", mapped[k]), c_err, 0);
      chk($sformatf("rd_dat_w%0d", mapped[k]), c_dat, 0);
      if (k == 0) begin
        chk("rd_no_ack_in_T", t_ack, 0);
        chk("rd_stall_in_T", t_stall, 1);
      end
    end
    foreach (unmapped[k]) begin
      xfer(1'b0, 6'(unmapped[k]), 32'h0, 4'h0);
      chk($sformatf("unm_err_w%0d", unmapped[k]), c_err, 1);
      chk($sformatf("unm_ack_w%0d", unmapped[k]), c_ack, 0);
    end
    xfer(1'b1, 6'd9, 32'hDEADBEEF, 4'hF);
    chk("w9_ack", c_ack, 1);
    chk("w9_wstb", c_wstb, 6'b010000);
    chk("w9_regs_T1", c_regs, exp_regs);
    exp_regs[4*32 +: 32] = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("w9_regs_T2", regs, exp_regs);
    xfer(1'b1, 6'd4, 32'h11223344, 4'hF);
    chk("w4_wstb", c_wstb, 6'b000001);
    xfer(1'b1, 6'd4, 32'hAABBCCDD, 4'h5);
    chk("w4_sel_wstb", c_wstb, 6'b000001);
    xfer(1'b0, 6'd4, 32'h0, 4'h0);
    chk("w4_readback", c_dat, 32'h11BB33DD);
    exp_regs[0 +: 32] = 32'h11BB33DD;
    chk("w4_regs", regs, exp_regs);
    xfer(1'b1, 6'd7, 32'h55555555, 4'hF);
    chk("w7_err", c_err, 1);
    chk("w7_ack", c_ack, 0);
    chk("w7_wstb", c_wstb, 0);
    @(posedge clk); #1;
    chk("w7_regs", regs, exp_regs);
    xfer(1'b1, 6'd0, 32'h12345678, 4'hF);
    chk("w0_ack", c_ack, 1);
    chk("w0_wstb", c_wstb, 0);
    @(posedge clk); #1;
    chk("w0_scratch", scr, 32'h12345678);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; a = 6'd5; n = 0;
    @(negedge clk);
    chk("hold_stall_T", stall, 1);
    n += int'(ack);
    @(negedge clk);
    chk("hold_stall_T1", stall, 0);
    n += int'(ack);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    n += int'(ack);
    @(negedge clk);
    n += int'(ack);
    chk("hold_one_ack", n, 1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; a = 6'd0; di = 32'hCAFEF00D; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rstd0_ack", ack, 0);
    chk("rstd0_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstd0_scratch", scr, 0);
    chk("rstd0_regs", regs, 0);
    chk("rstd0_ack_after", ack, 0);
    xfer(1'b1, 6'd44, 32'h0BADCAFE, 4'hF);
    chk("c5_w44_ack", c5_ack, 1);
    chk("c5_w44_wstb", c5_wstb, 25'h1000000);
    @(posedge clk); #1;
    chk("c5_w44_reg", regs5[24*32 +: 32], 32'h0BADCAFE);
    chk("c5_w44_other", regs5[23*32 +: 32], 0);
    xfer(1'b0, 6'd44, 32'h0, 4'h0);
    chk("c5_r44_ack", c5_ack, 1);
    chk("c5_r44_dat", c5_dat, 32'h0BADCAFE);
    xfer(1'b0, 6'd45, 32'h0, 4'h0);
    chk("c5_r45_err", c5_err, 1);
    chk("c5_r45_ack", c5_ack, 0);
    xfer(1'b0, 6'd48, 32'h0, 4'h0);
    chk("c5_r48_err", c5_err, 1);
    xfer(1'b0, 6'd8, 32'h0, 4'h0);
    chk("c5_r8_ack", c5_ack, 1);
    chk("c5_r8_dat", c5_dat, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
